// File: rtl/note_judge.sv
// note_judge: beat-timed judging stage of the Finger-Dancer core.
// Pulls one 4-lane note per beat, shows next/current note on LED, and
// judges the player's lane switch toggles into a BCD score, combo and lives.
//
// Upstream handshake: a note transfers only on a cycle where note_ready and
// note_valid are both high. note_ready is a one-cycle strobe (LOAD cycle and
// every beat tick in PLAY); note_valid low on a strobe inserts an empty note
// and marks the end of the stream.
`timescale 1ns/1ps
module note_judge #(
   parameter int unsigned BEAT_DIV = 25_000_000,
   parameter int unsigned LIVES    = 3
) (
   input  logic        board_clk,
   input  logic        rst_btn,
   input  logic        start,
   input  logic [3:0]  SW,
   input  logic        note_valid,
   input  logic [3:0]  note_lanes,
   output logic        note_ready,
   output logic [7:0]  LED,
   output logic [15:0] score,
   output logic [3:0]  count,
   output logic        game,
   output logic        cout,
   output logic [1:0]  state_o
);

   localparam int unsigned BW         = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_DIV - 1);
   localparam logic [3:0]   LIVES_INIT = 4'(LIVES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_PLAY = 2'd2,
      S_OVER = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [BW-1:0]  beat_q, beat_d;
   logic [3:0]     cur_q, cur_d;
   logic [3:0]     nxt_q, nxt_d;
   logic           end_q, end_d;
   logic [15:0]    score_q, score_d;
   logic [3:0]     combo_q, combo_d;
   logic [3:0]     count_q, count_d;
   logic [3:0]     mask_q, mask_d;
   logic [3:0]     sync1_q, sync2_q, prev_q;

   logic [3:0]     sw_edge;
   logic [3:0]     judge_mask;
   logic           tick;
   logic           hit;
   logic           miss;

   // Add 1 or 2 to a 4-digit BCD value; overflow past 9999 clamps to 9999.
   function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [1:0] inc);
      logic [15:0] r;
      logic [4:0]  d;
      logic [4:0]  add;
      r   = '0;
      add = {3'b000, inc};
      for (int i = 0; i < 4; i++) begin
         d = {1'b0, a[i*4 +: 4]} + add;
         if (d > 5'd9) begin
            r[i*4 +: 4] = 4'(d - 5'd10);
            add         = 5'd1;
         end else begin
            r[i*4 +: 4] = d[3:0];
            add         = 5'd0;
         end
      end
      if (add != 5'd0) r = 16'h9999;
      return r;
   endfunction

   assign sw_edge    = sync2_q ^ prev_q;
   assign judge_mask = mask_q | sw_edge;
   assign tick       = (state_q == S_PLAY) && (beat_q == BEAT_LAST);

   // Switch path: two-flop synchronizer followed by a previous-value register for edge detection.
   always_ff @(posedge board_clk or negedge rst_btn) begin
      if (!rst_btn) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= SW;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // State and game registers.
   always_ff @(posedge board_clk or negedge rst_btn) begin
      if (!rst_btn) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         cur_q   <= '0;
         nxt_q   <= '0;
         end_q   <= 1'b0;
         score_q <= '0;
         combo_q <= '0;
         count_q <= LIVES_INIT;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         cur_q   <= cur_d;
         nxt_q   <= nxt_d;
         end_q   <= end_d;
         score_q <= score_d;
         combo_q <= combo_d;
         count_q <= count_d;
         mask_q  <= mask_d;
      end
   end

   // Next-state logic: load, beat counting, judging and note shifting.
   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      cur_d      = cur_q;
      nxt_d      = nxt_q;
      end_d      = end_q;
      score_d    = score_q;
      combo_d    = combo_q;
      count_d    = count_q;
      mask_d     = mask_q;
      note_ready = 1'b0;
      cout       = 1'b0;
      hit        = 1'b0;
      miss       = 1'b0;

      unique case (state_q)
         S_IDLE, S_OVER: begin
            if (start) state_d = S_LOAD;
         end

         S_LOAD: begin
            note_ready = 1'b1;
            nxt_d      = note_valid ? note_lanes : 4'h0;
            end_d      = ~note_valid;
            cur_d      = '0;
            score_d    = '0;
            combo_d    = '0;
            count_d    = LIVES_INIT;
            mask_d     = '0;
            beat_d     = '0;
            state_d    = S_PLAY;
         end

         S_PLAY: begin
            mask_d = judge_mask;
            beat_d = beat_q + BW'(1);
            if (tick) begin
               cout       = 1'b1;
               note_ready = 1'b1;
               beat_d     = '0;

               if (cur_q != 4'h0) begin
                  if (judge_mask == cur_q) hit  = 1'b1;
                  else                     miss = 1'b1;
               end else if (judge_mask != 4'h0) begin
                  miss = 1'b1;
               end

               if (hit) begin
                  score_d = bcd_add(score_q, (combo_q >= 4'd4) ? 2'd2 : 2'd1);
                  combo_d = (combo_q == 4'd15) ? 4'd15 : combo_q + 4'd1;
               end
               if (miss) begin
                  count_d = (count_q != 4'd0) ? count_q - 4'd1 : 4'd0;
                  combo_d = '0;
               end

               cur_d  = nxt_q;
               nxt_d  = note_valid ? note_lanes : 4'h0;
               end_d  = end_q | ~note_valid;
               mask_d = '0;

               // Out of lives, or stream already ended and nothing left to judge.
               if ((miss && count_q <= 4'd1) || (end_q && nxt_q == 4'h0 && nxt_d == 4'h0))
                  state_d = S_OVER;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign LED     = {nxt_q, cur_q};
   assign score   = score_q;
   assign count   = count_q;
   assign game    = (state_q == S_PLAY);
   assign state_o = state_q;

endmodule
